control_ventilador: RTL and testbench

//  Consumes the decoded keyboard settings (temperatura, ignicion, presencia)
//  and their DatosListos strobe. Latches each new setting set.

---
 rtl/control_ventilador.sv | 174 +++++++++++++++++
 tb/tb_control_ventilador.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_ventilador.sv
// Cabin fan controller: latches keyboard settings, gates the fan on ignition and presence,
// and soft-starts a free-running PWM by stepping the duty once per PWM period.
module control_ventilador #(
  parameter int unsigned PRESCALE     = 4,
  parameter int unsigned T_LOW        = 16,
  parameter int unsigned T_HIGH       = 31,
  parameter int unsigned SHIFT        = 4,
  parameter int unsigned RAMP_STEP    = 32,
  parameter int unsigned DELAY_CYCLES = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] temperatura,
  input  logic       ignicion,
  input  logic       presencia,
  input  logic       datos_listos,
  output logic       pwm_out,
  output logic [7:0] duty_actual,
  output logic       ventilador_on,
  output logic [1:0] estado,
  output logic       alarma
);

  typedef enum logic [1:0] {
    APAGADO = 2'b00,
    ESPERA  = 2'b01,
    RAMPA   = 2'b10,
    ESTABLE = 2'b11
  } estado_t;

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [4:0]    temp_q, temp_d;
  logic          ign_q, ign_d;
  logic          pres_q, pres_d;
  estado_t       state_q, state_d;
  logic [15:0]   delay_q, delay_d;
  logic [7:0]    duty_q, duty_d;
  logic          von_q, von_d;
  logic          pwm_q, pwm_d;
  logic          alarma_q, alarma_d;

  logic       tick;
  logic       wrap;
  logic       en;
  logic [7:0] duty_obj;
  logic [7:0] duty_step;
  logic [7:0] temp_diff;
  logic [8:0] duty_up;

  assign tick = (presc_q == PW'(PRESCALE - 1));
  assign wrap = tick && (cnt_q == 8'd255);
  assign en   = ign_q & pres_q;

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    cnt_d   = tick ? cnt_q + 8'd1 : cnt_q;
    temp_d  = datos_listos ? temperatura : temp_q;
    ign_d   = datos_listos ? ignicion    : ign_q;
    pres_d  = datos_listos ? presencia   : pres_q;
  end

  // Target duty from the latched temperature code.
  always_comb begin
    temp_diff = {3'b000, temp_q} - 8'(T_LOW);
    if (temp_q <= 5'(T_LOW))
      duty_obj = 8'd0;
    else if (temp_q >= 5'(T_HIGH))
      duty_obj = 8'd255;
    else
      duty_obj = temp_diff << SHIFT;
  end

  // One ramp step toward the target; the 9-bit sum keeps the upward step from wrapping.
  always_comb begin
    duty_up = {1'b0, duty_q} + 9'(RAMP_STEP);
    if (duty_obj > duty_q)
      duty_step = (duty_up >= {1'b0, duty_obj}) ? duty_obj : duty_up[7:0];
    else if ((duty_q - duty_obj) > 8'(RAMP_STEP))
      duty_step = duty_q - 8'(RAMP_STEP);
    else
      duty_step = duty_obj;
  end

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    duty_d  = duty_q;
    if (!en) begin
      state_d = APAGADO;
      delay_d = 16'd0;
      duty_d  = 8'd0;
    end else begin
      case (state_q)
        APAGADO: begin
          state_d = ESPERA;
          delay_d = 16'd0;
          duty_d  = 8'd0;
        end
        ESPERA: begin
          if (delay_q == 16'(DELAY_CYCLES - 1)) begin
            state_d = RAMPA;
            delay_d = 16'd0;
          end else begin
            delay_d = delay_q + 16'd1;
          end
        end
        RAMPA: begin
          if (duty_q == duty_obj) begin
            state_d = ESTABLE;
          end else if (wrap) begin
            duty_d = duty_step;
            if (duty_step == duty_obj)
              state_d = ESTABLE;
          end
        end
        ESTABLE: begin
          if (duty_obj != duty_q)
            state_d = RAMPA;
        end
        default: state_d = APAGADO;
      endcase
    end
  end

  // PWM level is registered from the next counter and duty so it always matches duty_actual.
  always_comb begin
    if (duty_d == 8'd0)
      pwm_d = 1'b0;
    else if (duty_d == 8'd255)
      pwm_d = 1'b1;
    else
      pwm_d = (cnt_d < duty_d);
    von_d    = (duty_d != 8'd0);
    alarma_d = pres_q & ~ign_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q  <= '0;
      cnt_q    <= 8'd0;
      temp_q   <= 5'd0;
      ign_q    <= 1'b0;
      pres_q   <= 1'b0;
      state_q  <= APAGADO;
      delay_q  <= 16'd0;
      duty_q   <= 8'd0;
      von_q    <= 1'b0;
      pwm_q    <= 1'b0;
      alarma_q <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      temp_q   <= temp_d;
      ign_q    <= ign_d;
      pres_q   <= pres_d;
      state_q  <= state_d;
      delay_q  <= delay_d;
      duty_q   <= duty_d;
      von_q    <= von_d;
      pwm_q    <= pwm_d;
      alarma_q <= alarma_d;
    end
  end

  assign pwm_out       = pwm_q;
  assign duty_actual   = duty_q;
  assign ventilador_on = von_q;
  assign estado        = state_q;
  assign alarma        = alarma_q;

endmodule

// File: tb/tb_control_ventilador.sv
// Bench for control_ventilador: directed table, multi-cycle corner sequences and random strobes,
// every cycle compared against a cycle-count based reference model.
module tb_control_ventilador;

  localparam int P      = 4;
  localparam int PERIOD = 256 * P;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] temperatura = 5'd0;
  logic       ignicion = 1'b0;
  logic       presencia = 1'b0;
  logic       datos_listos = 1'b0;
  logic       pwm_out;
  logic [7:0] duty_actual;
  logic       ventilador_on;
  logic [1:0] estado;
  logic       alarma;

  control_ventilador dut (
    .clk          (clk),
    .rst          (rst),
    .temperatura  (temperatura),
    .ignicion     (ignicion),
    .presencia    (presencia),
    .datos_listos (datos_listos),
    .pwm_out      (pwm_out),
    .duty_actual  (duty_actual),
    .ventilador_on(ventilador_on),
    .estado       (estado),
    .alarma       (alarma)
  );

  always #5 clk = ~clk;

  int n_pass   = 0;
  int n_checks = 0;

  // Reference model: cycles since reset determine the PWM counter and wrap instants.
  int m_cyc, m_temp, m_ign, m_pres, m_st, m_delay, m_duty, m_alarm;

  function automatic int target(int t);
    if (t <= 16) return 0;
    if (t >= 31) return 255;
    return (t - 16) * 16;
  endfunction

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_edge();
    int  obj;
    bit  en, wr;
    if (!rst) begin
      m_cyc = 0; m_temp = 0; m_ign = 0; m_pres = 0;
      m_st = 0; m_delay = 0; m_duty = 0; m_alarm = 0;
      return;
    end
    obj     = target(m_temp);
    en      = (m_ign != 0) && (m_pres != 0);
    wr      = (m_cyc % PERIOD) == PERIOD - 1;
    m_alarm = (m_pres != 0 && m_ign == 0) ? 1 : 0;
    if (!en) begin
      m_st = 0; m_duty = 0; m_delay = 0;
    end else if (m_st == 0) begin
      m_st = 1; m_delay = 0;
    end else if (m_st == 1) begin
      if (m_delay == 99) m_st = 2;
      else m_delay++;
    end else if (m_st == 2) begin
      if (m_duty == obj) m_st = 3;
      else if (wr) begin
        if (obj > m_duty) m_duty = (m_duty + 32 > obj) ? obj : m_duty + 32;
        else              m_duty = (m_duty - 32 < obj) ? obj : m_duty - 32;
        if (m_duty == obj) m_st = 3;
      end
    end else if (m_duty != obj) begin
      m_st = 2;
    end
    if (datos_listos) begin
      m_temp = int'(temperatura); m_ign = int'(ignicion); m_pres = int'(presencia);
    end
    m_cyc++;
  endtask

  task automatic step();
    int cnt, exp_pwm, exp_v, act_v;
    @(posedge clk);
    model_edge();
    #1;
    cnt     = (m_cyc / P) % 256;
    exp_pwm = (m_duty == 0) ? 0 : (m_duty == 255) ? 1 : (cnt < m_duty ? 1 : 0);
    exp_v   = (m_st << 11) | (m_duty << 3) | ((m_duty != 0 ? 1 : 0) << 2) | (m_alarm << 1) | exp_pwm;
    act_v   = int'({estado, duty_actual, ventilador_on, alarma, pwm_out});
    check("cycle_model", act_v, exp_v);
  endtask

  task automatic strobe(int t, bit i, bit p);
    temperatura  = 5'(t);
    ignicion     = i;
    presencia    = p;
    datos_listos = 1'b1;
    step();
    datos_listos = 1'b0;
    temperatura  = 5'($urandom);
    ignicion     = 1'($urandom);
    presencia    = 1'($urandom);
  endtask

  typedef struct {
    int t; bit ign; bit pres; int wait_n; int st; int duty; int alarm;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hi, gap, t;
    bit i, p;

    tbl[0] = '{24, 1'b1, 1'b1, 6000, 3, 128, 0};
    tbl[1] = '{31, 1'b1, 1'b1, 5000, 3, 255, 0};
    tbl[2] = '{10, 1'b1, 1'b1, 9000, 3,   0, 0};
    tbl[3] = '{20, 1'b0, 1'b1,   10, 0,   0, 1};
    tbl[4] = '{20, 1'b1, 1'b1,   50, 1,   0, 0};
    tbl[5] = '{20, 1'b1, 1'b1, 3000, 3,  64, 0};
    tbl[6] = '{16, 1'b1, 1'b0,    5, 0,   0, 0};
    tbl[7] = '{17, 1'b1, 1'b1, 2000, 3,  16, 0};
    tbl[8] = '{ 5, 1'b1, 1'b1, 1500, 3,   0, 0};

    // Reset held low with a strobe present: nothing may be latched.
    rst = 1'b0; datos_listos = 1'b1; temperatura = 5'd31; ignicion = 1'b1; presencia = 1'b1;
    repeat (3) step();
    datos_listos = 1'b0;
    check("rst_estado", int'(estado), 0);
    check("rst_duty", int'(duty_actual), 0);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_von", int'(ventilador_on), 0);
    check("rst_alarma", int'(alarma), 0);
    rst = 1'b1;

    for (int k = 0; k < 9; k++) begin
      strobe(tbl[k].t, tbl[k].ign, tbl[k].pres);
      repeat (tbl[k].wait_n) step();
      check("tbl_estado", int'(estado), tbl[k].st);
      check("tbl_duty", int'(duty_actual), tbl[k].duty);
      check("tbl_von", int'(ventilador_on), (tbl[k].duty != 0) ? 1 : 0);
      check("tbl_alarma", int'(alarma), tbl[k].alarm);
      $display("vec %0d t=%0d ign=%0b pres=%0b -> estado=%0d duty=%0d alarma=%0b",
               k, tbl[k].t, tbl[k].ign, tbl[k].pres, estado, duty_actual, alarma);
    end

    // Duty 128: exactly half of one full PWM period high.
    strobe(24, 1'b1, 1'b1);
    repeat (6000) step();
    check("half_duty", int'(duty_actual), 128);
    check("half_estado", int'(estado), 3);
    hi = 0;
    for (int c = 0; c < PERIOD; c++) begin
      step();
      if (pwm_out) hi++;
    end
    check("pwm_high_cycles", hi, 128 * P);
    $display("seq pwm: duty=%0d high=%0d of %0d cycles", duty_actual, hi, PERIOD);

    // Ignition drops mid-ramp: off on the following edge, alarm raised.
    strobe(31, 1'b1, 1'b1);
    n = 0;
    while (duty_actual == 8'd128 && n < 2000) begin step(); n++; end
    check("ramp_first_step", int'(duty_actual), 160);
    check("ramp_estado", int'(estado), 2);
    strobe(31, 1'b0, 1'b1);
    step();
    check("ign_off_estado", int'(estado), 0);
    check("ign_off_duty", int'(duty_actual), 0);
    check("ign_off_pwm", int'(pwm_out), 0);
    check("ign_off_alarma", int'(alarma), 1);
    $display("seq ign_off: estado=%0d duty=%0d alarma=%0b", estado, duty_actual, alarma);

    // Re-strobe midway through ESPERA must not restart the delay.
    strobe(20, 1'b1, 1'b1);
    n = 0;
    while (estado != 2'b10 && n < 400) begin
      n++;
      if (n == 50) strobe(20, 1'b1, 1'b1);
      else step();
    end
    check("espera_len", n, 101);
    $display("seq espera: RAMPA reached after %0d cycles", n);

    // Reset in the middle of a ramp.
    n = 0;
    while (duty_actual == 8'd0 && n < 1500) begin step(); n++; end
    check("ramp64_first", int'(duty_actual), 32);
    check("ramp64_estado", int'(estado), 2);
    rst = 1'b0;
    step();
    check("midrst_estado", int'(estado), 0);
    check("midrst_duty", int'(duty_actual), 0);
    check("midrst_pwm", int'(pwm_out), 0);
    check("midrst_von", int'(ventilador_on), 0);
    check("midrst_alarma", int'(alarma), 0);
    rst = 1'b1;
    $display("seq midrst: estado=%0d duty=%0d", estado, duty_actual);

    for (int k = 0; k < 200; k++) begin
      t = $urandom_range(0, 31);
      i = ($urandom_range(0, 9) != 0);
      p = ($urandom_range(0, 9) != 0);
      strobe(t, i, p);
      gap = (k % 25 == 24) ? 1500 : $urandom_range(0, 60);
      repeat (gap) step();
      $display("rnd %0d t=%0d ign=%0b pres=%0b gap=%0d -> estado=%0d duty=%0d",
               k, t, i, p, gap, estado, duty_actual);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
